// File: rtl/router_pkg.sv
// Shared router definitions: port directions, crossbar select encodings
// and the default flit width used by the input buffers and arbiters.
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NUM_DIRS           = 5;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_W = 3'd2,
    DIR_S = 3'd3,
    DIR_L = 3'd4
  } dir_t;

  // One-hot crossbar selects, bit position matches dir_t.
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_N    = 5'b00001;
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_E    = 5'b00010;
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_W    = 5'b00100;
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_S    = 5'b01000;
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_L    = 5'b10000;
  localparam logic [NUM_DIRS-1:0] XBAR_SEL_NONE = 5'b00000;

  // True when any direction in the vector is requesting.
  function automatic logic any_dir(input logic [NUM_DIRS-1:0] v);
    return |v;
  endfunction

endpackage

// File: rtl/router_input_fifo_handshake_ctrl.sv
// DRTS/CTS link handshake: registers the CTS pulse and flags the edge on
// which the upstream flit is captured.
module fifo_handshake_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic drts,
  input  logic full,
  output logic cts,
  output logic wr_en
);

  logic cts_q;
  logic cts_d;

  // CTS rises only for a fresh request with room available, and drops the
  // cycle after so every flit costs a full request/grant round.
  always_comb begin
    cts_d = drts & ~cts_q & ~full;
  end

  // CTS register, cleared on reset so a pending grant is cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_q <= 1'b0;
    end else begin
      cts_q <= cts_d;
    end
  end

  assign cts   = cts_q;
  assign wr_en = drts & cts_q;

endmodule

// File: rtl/router_input_fifo.sv
// Per-port NoC router input buffer: circular show-ahead FIFO fed by the
// DRTS/CTS link and popped by any output arbiter grant.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [NUM_DIRS-1:0]   read_en_vec;
  logic                  read_en;
  logic                  wr_en;
  logic                  push;
  logic                  pop;

  fifo_handshake_ctrl u_hs (
    .clk   (clk),
    .rst   (rst),
    .drts  (DRTS),
    .full  (full),
    .cts   (CTS),
    .wr_en (wr_en)
  );

  assign read_en_vec[DIR_N] = read_en_N;
  assign read_en_vec[DIR_E] = read_en_E;
  assign read_en_vec[DIR_W] = read_en_W;
  assign read_en_vec[DIR_S] = read_en_S;
  assign read_en_vec[DIR_L] = read_en_L;

  assign read_en = any_dir(read_en_vec);
  // A reset edge drops the in-flight flit; a pop on empty is ignored, which
  // also hides a same-edge write into an empty buffer from the pop.
  assign push    = wr_en & ~rst;
  assign pop     = read_en & ~empty;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign Data_out = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= RX;
    end
  end

  // Arbiters grant one output per cycle, so at most one pop request is legal.
  a_single_read_en : assert property (@(posedge clk) disable iff (rst)
    $onehot0(read_en_vec));

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo: vector table plus hand sequences.
module tb_router_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RX;
  logic        DRTS;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full)
  );

  // rd bits: {L,S,W,E,N}. e_data checked only when e_empty is 0.
  typedef struct {
    logic        rst;
    logic        drts;
    logic [31:0] rx;
    logic [4:0]  rd;
    logic        e_cts;
    logic        e_empty;
    logic        e_full;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic d, logic [31:0] x, logic [4:0] rd,
                              logic c, logic e, logic f, logic [31:0] dat);
    vec_t v;
    v.rst = r; v.drts = d; v.rx = x; v.rd = rd;
    v.e_cts = c; v.e_empty = e; v.e_full = f; v.e_data = dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] rd);
    {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N} = rd;
  endtask

  // Raise DRTS, wait (bounded) for CTS, then let the write edge happen with
  // the given pop vector applied on that same edge.
  task automatic push_flit(input logic [31:0] val, input logic [4:0] rd_on_write);
    logic seen;
    seen = 1'b0;
    DRTS = 1'b1;
    RX   = val;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (CTS) begin
        seen = 1'b1;
        break;
      end
    end
    chk("cts_wait", {31'd0, seen}, 32'd1);
    set_rd(rd_on_write);
    @(posedge clk); #1;
    DRTS = 1'b0;
    set_rd(5'b0);
  endtask

  task automatic pop_l();
    read_en_L = 1'b1;
    @(posedge clk); #1;
    read_en_L = 1'b0;
  endtask

  initial begin
    rst = 1'b1; DRTS = 1'b0; RX = '0; set_rd(5'b0);

    //           rst drts rx            rd        cts e f data
    tbl[0]  = mk(1, 1, 32'hDEAD_0000, 5'b00000, 0, 1, 0, 32'h0);
    tbl[1]  = mk(1, 1, 32'hDEAD_0000, 5'b00000, 0, 1, 0, 32'h0);
    tbl[2]  = mk(0, 1, 32'hA5A5_0001, 5'b00000, 1, 1, 0, 32'h0);
    tbl[3]  = mk(0, 1, 32'hA5A5_0001, 5'b00000, 0, 0, 0, 32'hA5A5_0001);
    tbl[4]  = mk(0, 1, 32'h0000_00F1, 5'b00000, 1, 0, 0, 32'hA5A5_0001);
    tbl[5]  = mk(0, 1, 32'h0000_00F1, 5'b00000, 0, 0, 0, 32'hA5A5_0001);
    tbl[6]  = mk(0, 1, 32'h0000_00F2, 5'b00000, 1, 0, 0, 32'hA5A5_0001);
    tbl[7]  = mk(0, 1, 32'h0000_00F2, 5'b00000, 0, 0, 0, 32'hA5A5_0001);
    tbl[8]  = mk(0, 1, 32'h0000_00F3, 5'b00000, 1, 0, 0, 32'hA5A5_0001);
    tbl[9]  = mk(0, 1, 32'h0000_00F3, 5'b00000, 0, 0, 1, 32'hA5A5_0001);
    tbl[10] = mk(0, 1, 32'h0000_00F4, 5'b00000, 0, 0, 1, 32'hA5A5_0001);
    tbl[11] = mk(0, 1, 32'h0000_00F4, 5'b00000, 0, 0, 1, 32'hA5A5_0001);
    tbl[12] = mk(0, 1, 32'h0000_00F4, 5'b00010, 0, 0, 0, 32'h0000_00F1);
    tbl[13] = mk(0, 1, 32'h0000_00F4, 5'b00000, 1, 0, 0, 32'h0000_00F1);
    tbl[14] = mk(0, 1, 32'h0000_00F4, 5'b00000, 0, 0, 1, 32'h0000_00F1);
    tbl[15] = mk(0, 0, 32'h0,         5'b00001, 0, 0, 0, 32'h0000_00F2);
    tbl[16] = mk(0, 0, 32'h0,         5'b00001, 0, 0, 0, 32'h0000_00F3);
    tbl[17] = mk(0, 0, 32'h0,         5'b00001, 0, 0, 0, 32'h0000_00F4);
    tbl[18] = mk(0, 0, 32'h0,         5'b00001, 0, 1, 0, 32'h0);
    tbl[19] = mk(0, 0, 32'h0,         5'b00001, 0, 1, 0, 32'h0);
    tbl[20] = mk(0, 1, 32'hDEAD_0001, 5'b00000, 1, 1, 0, 32'h0);
    tbl[21] = mk(1, 1, 32'hDEAD_0001, 5'b00000, 0, 1, 0, 32'h0);
    tbl[22] = mk(0, 0, 32'h0,         5'b00000, 0, 1, 0, 32'h0);

    // Reset, single flit, fill/backpressure, drain, pop-on-empty, reset mid-CTS.
    for (int i = 0; i < NV; i++) begin
      rst  = tbl[i].rst;
      DRTS = tbl[i].drts;
      RX   = tbl[i].rx;
      set_rd(tbl[i].rd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_cts", i),   {31'd0, CTS},   {31'd0, tbl[i].e_cts});
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
      chk($sformatf("vec%0d_full", i),  {31'd0, full},  {31'd0, tbl[i].e_full});
      if (!tbl[i].e_empty)
        chk($sformatf("vec%0d_data", i), Data_out, tbl[i].e_data);
    end
    set_rd(5'b0);

    // Wrap: nine flits through one entry at a time, pointers wrap twice.
    for (int i = 0; i < 9; i++) begin
      push_flit(32'(i), 5'b00000);
      chk($sformatf("wrap%0d_empty", i), {31'd0, empty}, 32'd0);
      chk($sformatf("wrap%0d_data", i), Data_out, 32'(i));
      pop_l();
      chk($sformatf("wrap%0d_drained", i), {31'd0, empty}, 32'd1);
    end

    // Simultaneous push and pop at count 2.
    push_flit(32'h0000_00B0, 5'b00000);
    push_flit(32'h0000_00B1, 5'b00000);
    chk("pp_head_before", Data_out, 32'h0000_00B0);
    push_flit(32'h0000_00B2, 5'b01000);
    chk("pp_empty", {31'd0, empty}, 32'd0);
    chk("pp_full", {31'd0, full}, 32'd0);
    chk("pp_head_after", Data_out, 32'h0000_00B1);
    pop_l();
    chk("pp_tail", Data_out, 32'h0000_00B2);
    chk("pp_not_empty", {31'd0, empty}, 32'd0);
    pop_l();
    chk("pp_count2_drained", {31'd0, empty}, 32'd1);

    // Push and pop on the same edge while empty: pop ignored, one flit kept.
    push_flit(32'h0000_00C0, 5'b00100);
    chk("pe_empty", {31'd0, empty}, 32'd0);
    chk("pe_data", Data_out, 32'h0000_00C0);
    pop_l();
    chk("pe_drained", {31'd0, empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
